// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch types: entry bundle, fetch FSM states, PC helpers.
// IF_MISALIGN_TRAP_EN adds the S_FAULT state for misaligned redirect targets.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH
`ifdef IF_MISALIGN_TRAP_EN
    ,
    S_FAULT
`endif
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_inc(
    input logic [XLEN-1:0] pc
  );
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] pc_align(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} entries with flush.
// Wrapping pointers plus a separate occupancy count.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       rptr;
  logic [AW-1:0]       wptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full buffer may still accept a word when the head leaves.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC owner, imem master, fetch buffer, redirect flush.
// IF_MISALIGN_TRAP_EN adds fetch_fault and the S_FAULT trap state.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic          push;
  logic          pop;
  logic          flush;
  fetch_entry_t  wdata;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  assign imem_addr = pc;
  assign wdata     = '{pc: pc, instr: imem_rdata};
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = pc_inc(head.pc);

`ifdef IF_MISALIGN_TRAP_EN
  assign fetch_fault = (state == S_FAULT);
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state)
      S_BOOT: begin
        state_next = S_FETCH;
      end
      default: begin
        if (redirect_valid) begin
          flush = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
          pc_next    = redirect_pc;
          state_next = (|redirect_pc[1:0]) ? S_FAULT : S_FETCH;
`else
          pc_next    = pc_align(redirect_pc);
`endif
        end else if (state == S_FETCH && (!full || pop)) begin
          push    = 1'b1;
          pc_next = pc_inc(pc);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  a_count_bound: assert property (
    @(posedge clk) disable iff (!rst_n)
    count <= CW'(FIFO_DEPTH)
  );

endmodule
